// File: rtl/count_seq_checker_if.sv
// Count-bus bundle between a free-running counter (or its stand-in) and the sequence checker.
// The master side drives samples and clear; the slave side reports lock status and statistics.
interface count_seq_checker_if #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
);
  logic             sample_en;
  logic [WIDTH-1:0] count;
  logic             clear;
  logic             locked;
  logic             mismatch;
  logic [WIDTH-1:0] exp_count;
  logic [ERR_W-1:0] err_count;
  logic [ERR_W-1:0] wrap_count;

  modport master (
    output sample_en, count, clear,
    input  locked, mismatch, exp_count, err_count, wrap_count
  );

  modport slave (
    input  sample_en, count, clear,
    output locked, mismatch, exp_count, err_count, wrap_count
  );
endinterface

// File: rtl/count_seq_checker.sv
// Locks onto a +1 modulo-2^WIDTH count stream, then flags out-of-sequence samples and keeps
// saturating error and wrap statistics.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   SEARCH | no reference yet; the next sample seeds exp_count
//   VERIFY | building a run of consecutive in-sequence samples toward lock
//   TRACK  | locked; every sample is checked, mismatches are counted
module count_seq_checker #(
  parameter int WIDTH  = 3,
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic                 Clk,
  input  logic                 reset,
  count_seq_checker_if.slave   bus
);

  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam logic [RUN_W-1:0] LOCK_V  = RUN_W'(LOCK_N);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ERR_W-1:0] STAT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    TRACK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_count_q, exp_count_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             mismatch_q, mismatch_d;
  logic             locked_q, locked_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [ERR_W-1:0] wrap_count_q, wrap_count_d;

  logic             in_seq;
  logic [WIDTH-1:0] count_inc;
  logic [RUN_W-1:0] run_inc;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= SEARCH;
      exp_count_q  <= '0;
      run_q        <= '0;
      mismatch_q   <= 1'b0;
      locked_q     <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      exp_count_q  <= exp_count_d;
      run_q        <= run_d;
      mismatch_q   <= mismatch_d;
      locked_q     <= locked_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    exp_count_d  = exp_count_q;
    run_d        = run_q;
    mismatch_d   = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;

    in_seq    = (bus.count == exp_count_q);
    count_inc = bus.count + WIDTH'(1);
    run_inc   = run_q + RUN_W'(1);

    if (bus.sample_en) begin
      case (state_q)
        SEARCH: begin
          exp_count_d = count_inc;
          run_d       = RUN_W'(1);
          state_d     = VERIFY;
        end
        VERIFY: begin
          if (in_seq) begin
            exp_count_d = exp_count_q + WIDTH'(1);
            run_d       = run_inc;
            if (run_inc == LOCK_V) state_d = TRACK;
          end else begin
            exp_count_d = count_inc;
            run_d       = RUN_W'(1);
          end
        end
        TRACK: begin
          if (in_seq) begin
            exp_count_d = exp_count_q + WIDTH'(1);
            if (bus.count == CNT_MAX && wrap_count_q != STAT_MAX)
              wrap_count_d = wrap_count_q + ERR_W'(1);
          end else begin
            // Resync from the offending sample rather than falling back to SEARCH.
            mismatch_d  = 1'b1;
            exp_count_d = count_inc;
            run_d       = RUN_W'(1);
            state_d     = VERIFY;
            if (err_count_q != STAT_MAX)
              err_count_d = err_count_q + ERR_W'(1);
          end
        end
        default: begin
          state_d = SEARCH;
        end
      endcase
    end

    if (bus.clear) begin
      err_count_d  = '0;
      wrap_count_d = '0;
    end

    locked_d = (state_d == TRACK);
  end

  assign bus.locked     = locked_q;
  assign bus.mismatch   = mismatch_q;
  assign bus.exp_count  = exp_count_q;
  assign bus.err_count  = err_count_q;
  assign bus.wrap_count = wrap_count_q;

endmodule

// File: doc/count_seq_checker.md
# count_seq_checker

Hardware sequence checker for the free-running binary up-counter output. Samples a WIDTH-bit count stream, locks onto the expected +1 modulo-2^WIDTH sequence, then flags every out-of-sequence sample. Keeps saturating error and wrap statistics. Sits on the consumer side of the counter's count bus, as the on-chip equivalent of the bench-side expected-count checker.

## Interface
Parameters:
- WIDTH, 3, width of the observed count bus.
- LOCK_N, 4, number of consecutive in-sequence samples, first one included, required to declare lock; legal range 2..15.
- ERR_W, 8, width of the err_count and wrap_count statistics.

Ports:
- Clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- sample_en  input  1  count is valid and sampled on this edge.
- count  input  WIDTH  observed counter value.
- clear  input  1  synchronous clear of statistics only.
- locked  output  1  checker is in TRACK.
- mismatch  output  1  one-cycle pulse: the sample taken in TRACK was out of sequence.
- exp_count  output  WIDTH  next expected value.
- err_count  output  ERR_W  mismatches seen in TRACK, saturating.
- wrap_count  output  ERR_W  in-sequence samples of 2^WIDTH−1 seen in TRACK, saturating.

## Operation
- States: SEARCH, VERIFY, TRACK. Internal run counter is sized to hold LOCK_N.
- SEARCH, on sample: exp_count ← count+1 mod 2^WIDTH; run ← 1; go to VERIFY.
- VERIFY, sample equals exp_count: exp_count ← exp_count+1; run ← run+1. If run+1 = LOCK_N, go to TRACK.
- VERIFY, sample differs: exp_count ← count+1; run ← 1; stay in VERIFY. No error is counted.
- TRACK, sample equals exp_count: exp_count ← exp_count+1. If count = 2^WIDTH−1, increment wrap_count, saturating at all-ones.
- TRACK, sample differs: mismatch ← 1; increment err_count, saturating; exp_count ← count+1; run ← 1; go to VERIFY. locked drops. This is a resync, not a return to SEARCH.
- sample_en low: state, exp_count, run and statistics hold; mismatch ← 0.
- All arithmetic on exp_count wraps modulo 2^WIDTH. 7+1 = 0 when WIDTH=3.
- clear zeroes err_count and wrap_count only. If clear coincides with an increment, clear wins and the result is 0.
- locked = (state == TRACK), driven from a register.

## Timing
- All outputs are registered. A sample taken at edge N is reflected in the outputs after edge N.
- mismatch is high for exactly one cycle per offending sample. Back-to-back bad samples produce back-to-back pulses only while in TRACK. The first bad sample leaves TRACK, so consecutive bad samples give a single pulse.
- Lock latency: locked rises after the edge that takes the LOCK_N-th consecutive in-sequence sample.
- Reset values: state SEARCH, locked 0, mismatch 0, exp_count 0, err_count 0, wrap_count 0, run 0.
- Reset has priority over sample_en and clear. Reset asserted mid-TRACK clears everything on that edge, and a full relock is then required.

## Test plan
- Reset 2 cycles, then count 0,1,2,…,7,0,1 with sample_en=1 every cycle -> locked rises after the sample of 3; wrap_count=1 after the sample of 7; err_count=0; mismatch never asserted.
- Locked on 0,1,2,3,4,5, then 2,3,4,5 -> mismatch pulses one cycle after sample 2; err_count=1; locked=0; exp_count=3; locked returns after the sample of 5.
- ERR_W=2, locked, then five glitches, each followed by a 4-sample relock -> err_count goes 1,2,3,3,3.
- Locked, clear asserted on the same edge as an out-of-sequence sample -> err_count=0, mismatch=1, locked=0.
- sample_en toggled 1,0,0,1,0,1 with count advancing only on enabled cycles, values 0,1,2,3 -> locked after sample 3; state and exp_count hold through gaps; err_count=0.
- Reset pulsed for one cycle while locked with err_count=2 and wrap_count=1 -> next cycle all outputs are 0 and the state is SEARCH; relock takes 4 samples.
